bin_2_bcd_seq: RTL and testbench
================================

# bin_2_bcd_seq

Sequential binary-to-BCD converter using shift-and-add-3 (double dabble), one bit per clock. Takes an unsigned binary value (e.g. switch inputs or a counter) and produces packed BCD digits. Each output nibble drives one hex-to-seven-segment decoder, so displays show decimal instead of hexadecimal. A start/busy/done handshake lets a display controller request conversions.

## Interface
- WIDTH, 10: bit width of the binary input.
- DIGITS, 4: number of BCD output digits. Must satisfy 10^DIGITS > 2^WIDTH − 1; elaboration fails otherwise.
- clk  input  1  sole clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- start  input  1  conversion request; sampled only in IDLE.
- bin  input  WIDTH  binary operand; sampled on the edge that accepts start.
- busy  output  1  high while a conversion is in progress.
- done  output  1  single-cycle pulse when bcd has been updated.
- bcd  output  4*DIGITS  packed BCD result, digit 0 in bits [3:0]; held until the next completion.

## Operation
- States: IDLE, SHIFT.
- IDLE with start=1 on an edge (the accept edge):
  - load bin into the binary shift register;
  - clear the BCD scratch register;
  - clear the bit counter;
  - go to SHIFT.
- IDLE with start=0: hold.
- SHIFT, each edge:
  - every scratch digit ≥5 gets +3 (combinational adjust);
  - then {scratch, binary} shifts left by one;
  - counter increments.
- SHIFT, edge performing shift number WIDTH:
  - bcd ← final shifted scratch;
  - done ← 1 for one cycle;
  - return to IDLE.
- start while busy is ignored, not queued. bin changes during SHIFT have no effect.
- Counter width is clog2(WIDTH+1). Scratch is 4*DIGITS bits. Bits shifted out of the top digit are discarded; the DIGITS constraint guarantees none are lost.
- Reset (asserted at any time, including mid-conversion):
  - state = IDLE, busy = 0, done = 0, bcd = 0, counter and scratch = 0;
  - any conversion in progress is abandoned; no done pulse follows.

## Timing
- Accept edge E0. Shifts occur on E1..E_WIDTH.
- busy is high from after E0 until after E_WIDTH (busy = state==SHIFT).
- done is high and bcd is new during the cycle between E_WIDTH and E_WIDTH+1. Latency is WIDTH cycles from accept to done.
- start=1 during the done cycle is accepted at E_WIDTH+1. Continuous start therefore gives one result every WIDTH+1 cycles.
- All outputs are registered; no combinational path from start or bin to any output.

## Structure
- Shared package/header bcd_pkg holds:
  - state encodings (IDLE, SHIFT);
  - BCD_DIGIT_W = 4;
  - the add-3 threshold constant 5.
- One sub-module, bcd_digit_adj: 4-bit combinational adjust (out = in≥5 ? in+3 : in). Instantiated DIGITS times via generate.
- Top level holds the FSM, counter, shift registers and output register.

## Test plan
- Reset, then start with bin=0 → done after 10 cycles, bcd=16'h0000, busy low afterward.
- bin=10'd1023 → bcd=16'h1023 exactly 10 cycles after accept; done high exactly one cycle.
- bin=10'd999, then start pulsed again at cycle 4 with bin=10'd5 → second start ignored, bcd=16'h0999, only one done pulse.
- start held high, bin alternating 10'd42 / 10'd700 at each accept → done every 11 cycles, bcd 16'h0042 then 16'h0700.
- Start bin=10'd512, assert rst_n=0 at cycle 5 → busy, done and bcd go to 0 immediately (asynchronously). After release, no done pulse until a new start.
- Exhaustive sweep bin=0..1023 → every bcd matches the decimal digits of bin; no digit exceeds 9.

Source files
------------

// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared encodings and constants for the binary-to-BCD converter
package bcd_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  localparam int         BCD_DIGIT_W    = 4;
  localparam logic [3:0] ADD3_THRESHOLD = 4'd5;

  // True when DIGITS decimal digits can hold the largest WIDTH-bit value.
  function automatic bit digits_ok(input int width, input int digits);
    longint pow10;
    longint max_bin;
    pow10 = 1;
    for (int i = 0; i < digits; i++) pow10 = pow10 * 10;
    max_bin = (longint'(1) << width) - 1;
    return pow10 > max_bin;
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// rtl/bcd_digit_adj.sv - add-3 correction for one BCD digit before each shift
module bcd_digit_adj
  import bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] digit_i,
  output logic [BCD_DIGIT_W-1:0] digit_o
);

  assign digit_o = (digit_i >= ADD3_THRESHOLD) ? digit_i + 4'd3 : digit_i;

endmodule

// File: rtl/bin_2_bcd_seq.sv
// rtl/bin_2_bcd_seq.sv - sequential double-dabble converter, one input bit per clock
module bin_2_bcd_seq
  import bcd_pkg::*;
#(
  parameter int WIDTH  = 10,
  parameter int DIGITS = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic [WIDTH-1:0]               bin,
  output logic                           busy,
  output logic                           done,
  output logic [BCD_DIGIT_W*DIGITS-1:0]  bcd
);

  localparam int SCR_W = BCD_DIGIT_W * DIGITS;
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  if (!digits_ok(WIDTH, DIGITS)) begin : g_bad_digits
    $error("bin_2_bcd_seq: DIGITS too small for WIDTH");
  end

  state_e             state_q;
  logic               busy_q;
  logic               done_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   bin_q;
  logic [SCR_W-1:0]   scr_q;
  logic [SCR_W-1:0]   bcd_q;

  logic [SCR_W-1:0]   scr_adj;
  logic [SCR_W-1:0]   scr_d;
  logic [WIDTH-1:0]   bin_d;
  logic               unused_adj_msb;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .digit_i (scr_q[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .digit_o (scr_adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  // The top scratch bit falls off the shift; the digit count guarantees it is zero.
  assign {scr_d, bin_d}  = {scr_adj[SCR_W-2:0], bin_q, 1'b0};
  assign unused_adj_msb  = scr_adj[SCR_W-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
      bin_q   <= '0;
      scr_q   <= '0;
      bcd_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            bin_q   <= bin;
            scr_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          scr_q <= scr_d;
          bin_q <= bin_d;
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == LAST_CNT) begin
            bcd_q   <= scr_d;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign bcd  = bcd_q;

endmodule

// File: tb/tb_bin_2_bcd_seq.sv
// tb/tb_bin_2_bcd_seq.sv - directed self-checking bench for bin_2_bcd_seq
module tb_bin_2_bcd_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [9:0]  bin;
  logic        busy;
  logic        done;
  logic [15:0] bcd;

  int total;
  int bad;

  bin_2_bcd_seq #(.WIDTH(10), .DIGITS(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .bcd   (bcd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Called at a negedge; returns at the negedge just after the accept edge.
  task automatic start_conv(input logic [9:0] v);
    start = 1'b1;
    bin   = v;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Counts negedges from the one after the accept edge until done is seen.
  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!done && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
    total++; if (bcd !== 16'h0000) begin bad++; $display("FAIL reset_bcd got=%h exp=0000", bcd); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_zero;
    int lat;
    start_conv(10'd0);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL zero_busy_after_accept got=%b exp=1", busy); end
    wait_done(lat);
    total++; if (lat != 10) begin bad++; $display("FAIL zero_latency got=%0d exp=10", lat); end
    total++; if (bcd !== 16'h0000) begin bad++; $display("FAIL zero_bcd got=%h exp=0000", bcd); end
    @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL zero_busy_after got=%b exp=0", busy); end
  endtask

  task automatic test_max;
    int lat;
    start_conv(10'd1023);
    wait_done(lat);
    total++; if (lat != 10) begin bad++; $display("FAIL max_latency got=%0d exp=10", lat); end
    total++; if (bcd !== 16'h1023) begin bad++; $display("FAIL max_bcd got=%h exp=1023", bcd); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL max_busy_at_done got=%b exp=0", busy); end
    @(negedge clk);
    total++; if (done !== 1'b0) begin bad++; $display("FAIL max_done_one_cycle got=%b exp=0", done); end
    total++; if (bcd !== 16'h1023) begin bad++; $display("FAIL max_bcd_held got=%h exp=1023", bcd); end
  endtask

  task automatic test_ignore_start;
    int ndone;
    int dcyc;
    logic [15:0] dval;
    ndone = 0;
    dcyc  = -1;
    dval  = 16'hxxxx;
    start_conv(10'd999);
    for (int c = 1; c <= 25; c++) begin
      @(negedge clk);
      if (done) begin
        ndone++;
        dcyc = c;
        dval = bcd;
      end
      if (c == 4) begin
        start = 1'b1;
        bin   = 10'd5;
      end else begin
        start = 1'b0;
      end
    end
    total++; if (ndone != 1) begin bad++; $display("FAIL ignore_done_count got=%0d exp=1", ndone); end
    total++; if (dcyc != 10) begin bad++; $display("FAIL ignore_done_cycle got=%0d exp=10", dcyc); end
    total++; if (dval !== 16'h0999) begin bad++; $display("FAIL ignore_bcd got=%h exp=0999", dval); end
  endtask

  task automatic test_back_to_back;
    int d1;
    int d2;
    logic [15:0] v1;
    logic [15:0] v2;
    d1 = -1;
    d2 = -1;
    v1 = 16'hxxxx;
    v2 = 16'hxxxx;
    start = 1'b1;
    bin   = 10'd42;
    @(negedge clk);
    bin   = 10'd700;
    for (int c = 1; c <= 30 && d2 < 0; c++) begin
      @(negedge clk);
      if (done) begin
        if (d1 < 0) begin
          d1 = c;
          v1 = bcd;
        end else begin
          d2 = c;
          v2 = bcd;
          start = 1'b0;
        end
      end
    end
    start = 1'b0;
    total++; if (d1 != 10) begin bad++; $display("FAIL b2b_first_cycle got=%0d exp=10", d1); end
    total++; if (v1 !== 16'h0042) begin bad++; $display("FAIL b2b_first_bcd got=%h exp=0042", v1); end
    total++; if (d2 != 21) begin bad++; $display("FAIL b2b_second_cycle got=%0d exp=21", d2); end
    total++; if (v2 !== 16'h0700) begin bad++; $display("FAIL b2b_second_bcd got=%h exp=0700", v2); end
    repeat (12) @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL b2b_idle_after got=%b exp=0", busy); end
  endtask

  task automatic test_reset_mid;
    int ndone;
    ndone = 0;
    start_conv(10'd512);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL rstmid_done got=%b exp=0", done); end
    total++; if (bcd !== 16'h0000) begin bad++; $display("FAIL rstmid_bcd got=%h exp=0000", bcd); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    total++; if (ndone != 0) begin bad++; $display("FAIL rstmid_no_done got=%0d exp=0", ndone); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy_after got=%b exp=0", busy); end
  endtask

  task automatic test_sweep;
    int lat;
    logic [15:0] exp_bcd;
    for (int v = 0; v < 1024; v++) begin
      exp_bcd = {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
      start_conv(10'(v));
      wait_done(lat);
      total++;
      if (bcd !== exp_bcd || lat != 10) begin
        bad++;
        $display("FAIL sweep_%0d got=%h lat=%0d exp=%h lat=10", v, bcd, lat, exp_bcd);
      end
      total++;
      if (bcd[3:0] > 4'd9 || bcd[7:4] > 4'd9 || bcd[11:8] > 4'd9 || bcd[15:12] > 4'd9) begin
        bad++;
        $display("FAIL sweep_digit_range_%0d got=%h exp=digits<=9", v, bcd);
      end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    start = 1'b0;
    bin   = '0;
    @(negedge clk);
    test_reset;
    test_zero;
    test_max;
    test_ignore_start;
    test_back_to_back;
    test_reset_mid;
    test_sweep;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
